// File: rtl/prng_pkg.sv
// Shared constants, mode encoding and the Fibonacci LFSR step used by the
// dual-LFSR byte generator.
package prng_pkg;

    localparam int unsigned LFSR_MAX_W    = 64;
    localparam logic [15:0] DEF_DATA_TAPS = 16'hD008;
    localparam logic [7:0]  DEF_CTRL_TAPS = 8'hB8;
    localparam logic [15:0] DEF_DATA_SEED = 16'hACE1;
    localparam logic [7:0]  DEF_CTRL_SEED = 8'h5A;
    localparam int unsigned DEF_DIV       = 10_000_000;
    localparam int unsigned DEF_CTRL_DIV  = 1;

    typedef enum logic {
        MODE_FREE = 1'b0,
        MODE_BP   = 1'b1
    } prng_mode_e;

    // One Fibonacci step of a w-bit register held in the low bits of state.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] taps,
        input int unsigned           w
    );
        logic [LFSR_MAX_W-1:0] mask;
        logic                  fb;
        mask = (LFSR_MAX_W'(1) << w) - LFSR_MAX_W'(1);
        fb   = ^(state & taps & mask);
        return ((state << 1) | LFSR_MAX_W'(fb)) & mask;
    endfunction

endpackage

// File: rtl/prng_tick_gen.sv
// Step-tick prescaler: one tick per DIV enabled cycles, freezes when disabled,
// restarts from zero on clear.
module prng_tick_gen #(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick_c
);

    localparam int unsigned    CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_wrap;

    assign w_wrap   = (r_cnt == LAST);
    assign o_tick_c = i_en && w_wrap;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/prng_dual_lfsr.sv
// Pseudo-random sample generator: a data LFSR supplies bit pairs, a slower
// control LFSR selects one bit of each pair; valid/ready output with overrun flag.
module prng_dual_lfsr
    import prng_pkg::*;
#(
    parameter int unsigned        OUT_W     = 8,
    parameter int unsigned        DATA_W    = 16,
    parameter logic [DATA_W-1:0]  DATA_TAPS = DATA_W'(DEF_DATA_TAPS),
    parameter logic [OUT_W-1:0]   CTRL_TAPS = OUT_W'(DEF_CTRL_TAPS),
    parameter logic [DATA_W-1:0]  DATA_SEED = DATA_W'(DEF_DATA_SEED),
    parameter logic [OUT_W-1:0]   CTRL_SEED = OUT_W'(DEF_CTRL_SEED),
    parameter int unsigned        DIV       = DEF_DIV,
    parameter int unsigned        CTRL_DIV  = DEF_CTRL_DIV
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              mode,
    input  logic              seed_load,
    input  logic [DATA_W-1:0] seed_data,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              overrun
);

    localparam int unsigned      CCNT_W    = (CTRL_DIV > 1) ? $clog2(CTRL_DIV) : 1;
    localparam logic [CCNT_W-1:0] CCNT_LAST = CCNT_W'(CTRL_DIV - 1);

    logic [DATA_W-1:0] r_data;
    logic [OUT_W-1:0]  r_ctrl;
    logic [CCNT_W-1:0] r_ctrl_cnt;
    logic [OUT_W-1:0]  r_out_data;
    logic              r_valid;
    logic              r_overrun;

    logic              w_tick;
    logic              w_stall;
    logic              w_step;
    logic              w_ctrl_wrap;
    logic [DATA_W-1:0] w_data_step;
    logic [OUT_W-1:0]  w_ctrl_step;
    logic [OUT_W-1:0]  w_ctrl_next;
    logic [OUT_W-1:0]  w_map;

    prng_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk      (clk),
        .reset    (reset),
        .i_en     (en),
        .i_clr    (seed_load),
        .o_tick_c (w_tick)
    );

    // A backpressure stall drops the tick rather than deferring it.
    assign w_stall     = (mode == MODE_BP) && r_valid && !out_ready;
    assign w_step      = w_tick && !w_stall;
    assign w_ctrl_wrap = (r_ctrl_cnt == CCNT_LAST);

    // Next states; the zero guard keeps the registers out of lock-up for any tap mask.
    always_comb begin
        w_data_step = DATA_W'(lfsr_next(LFSR_MAX_W'(r_data), LFSR_MAX_W'(DATA_TAPS), DATA_W));
        w_ctrl_step = OUT_W'(lfsr_next(LFSR_MAX_W'(r_ctrl), LFSR_MAX_W'(CTRL_TAPS), OUT_W));
        if (w_data_step == '0) begin
            w_data_step = DATA_SEED;
        end
        if (w_ctrl_step == '0) begin
            w_ctrl_step = CTRL_SEED;
        end
        w_ctrl_next = w_ctrl_wrap ? w_ctrl_step : r_ctrl;
    end

    // Sample bit i picks one bit of data pair i under control bit i, post-step.
    always_comb begin
        w_map = '0;
        for (int i = 0; i < int'(OUT_W); i++) begin
            w_map[i] = w_ctrl_next[i] ? w_data_step[2*i+1] : w_data_step[2*i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data     <= DATA_SEED;
            r_ctrl     <= CTRL_SEED;
            r_ctrl_cnt <= '0;
            r_out_data <= '0;
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
        end else if (seed_load) begin
            r_data     <= (seed_data == '0) ? DATA_SEED : seed_data;
            r_ctrl     <= (seed_data[OUT_W-1:0] == '0) ? CTRL_SEED : seed_data[OUT_W-1:0];
            r_ctrl_cnt <= '0;
            r_valid    <= 1'b0;
            r_overrun  <= 1'b0;
        end else if (w_step) begin
            r_data     <= w_data_step;
            r_ctrl     <= w_ctrl_next;
            r_ctrl_cnt <= w_ctrl_wrap ? '0 : r_ctrl_cnt + CCNT_W'(1);
            r_out_data <= w_map;
            r_valid    <= 1'b1;
            if (r_valid && !out_ready) begin
                r_overrun <= 1'b1;
            end
        end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_valid;
    assign overrun   = r_overrun;

endmodule
